// File: rtl/cpu_pkg.sv
// Shared core definitions: data width, opcode constants and the fetch-stage state encoding.
// The FAULT state exists only when PC_ALIGN_CHECK_EN is defined.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_BEQ = 6'd32;
  localparam logic [5:0] OP_BNE = 6'd33;
  localparam logic [5:0] OP_BLT = 6'd34;
  localparam logic [5:0] OP_BLE = 6'd35;
  localparam logic [5:0] OP_J   = 6'd40;
  localparam logic [5:0] OP_JR  = 6'd42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_WAIT_NPC
`ifdef PC_ALIGN_CHECK_EN
    ,
    ST_FAULT
`endif
  } fetch_state_t;

  // Word-offset branch displacement: sign-extend the 16-bit immediate and scale by 4.
  function automatic logic [XLEN-1:0] branch_disp(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates derived from the captured instruction and its PC.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_STEP = 32'd4
) (
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] nonbranch,
  output logic [XLEN-1:0] branch,
  output logic [XLEN-1:0] addr
);

  // All adds wrap at 32 bits; carries are dropped.
  assign nonbranch = inst_pc + PC_STEP;
  assign branch    = nonbranch + branch_disp(inst[15:0]);
  assign addr      = {nonbranch[31:28], inst[25:0], 2'b00};

endmodule

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch; waits for the resolved npc each instruction.
// Define PC_ALIGN_CHECK_EN to trap misaligned npc values into a sticky FAULT state.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] nonbranch,
  output logic [XLEN-1:0] branch,
  output logic [XLEN-1:0] addr,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] npc,
  input  logic            npc_valid,
  output logic            fetch_fault
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] inst_reg, inst_next;
  logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
`ifdef PC_ALIGN_CHECK_EN
  logic            fault_reg, fault_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      inst_reg    <= '0;
      inst_pc_reg <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
`ifdef PC_ALIGN_CHECK_EN
      fault_reg   <= fault_next;
`endif
    end
  end

  // Shared npc load path for HOLD (same-cycle resolve) and WAIT_NPC.
  task automatic load_npc(output fetch_state_t st, inout logic [XLEN-1:0] pc
`ifdef PC_ALIGN_CHECK_EN
                          , inout logic flt
`endif
                          );
`ifdef PC_ALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      st  = ST_FAULT;
      flt = 1'b1;
    end else begin
      st = ST_REQ;
      pc = npc;
    end
`else
    st = ST_REQ;
    pc = npc & ~32'h3;
`endif
  endtask

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
`ifdef PC_ALIGN_CHECK_EN
    fault_next   = fault_reg;
`endif
    imem_req     = 1'b0;
    inst_valid   = 1'b0;

    unique case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_next    = imem_data;
          inst_pc_next = pc_reg;
          state_next   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          if (npc_valid) begin
`ifdef PC_ALIGN_CHECK_EN
            load_npc(state_next, pc_next, fault_next);
`else
            load_npc(state_next, pc_next);
`endif
          end else begin
            state_next = ST_WAIT_NPC;
          end
        end
      end
      ST_WAIT_NPC: begin
        if (npc_valid) begin
`ifdef PC_ALIGN_CHECK_EN
          load_npc(state_next, pc_next, fault_next);
`else
          load_npc(state_next, pc_next);
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      ST_FAULT: state_next = ST_FAULT;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_reg;
  assign inst      = inst_reg;
  assign inst_pc   = inst_pc_reg;
`ifdef PC_ALIGN_CHECK_EN
  assign fetch_fault = fault_reg;
`else
  assign fetch_fault = 1'b0;
`endif

  pc_target_calc #(
    .PC_STEP(PC_STEP)
  ) u_target (
    .inst     (inst_reg),
    .inst_pc  (inst_pc_reg),
    .nonbranch(nonbranch),
    .branch   (branch),
    .addr     (addr)
  );

endmodule
